apb_arbiter_master: RTL and testbench
=====================================

# apb_arbiter_master

Round-robin APB master that shares one APB slave (the 256-word register/memory slave at base 0x4000_0000) between NUM_REQ on-chip requesters. Each requester issues single read/write commands over a valid/ready request channel. The block arbitrates between them, sequences the APB SETUP/ACCESS phases, and returns read data and the slave's 2-bit error code on a per-requester response pulse. It sits between the requester fabric and the slave's PSEL/PENABLE/PADDR/PWDATA/PWRITE inputs.

## Interface
- NUM_REQ, 2: number of requesters; legal range 2..8.
- ADDR_W, 32: APB address width.
- DATA_W, 32: APB data width.
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase cycles before abort. Used only with APB_ARB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset PRESETn, asynchronous, active-low; clock PCLK
- req_valid  in  NUM_REQ  per-requester command valid
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot accept strobe (combinational)
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid
- rsp_err  out  2  00 ok, 01 write error, 10 read error, 11 timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  2  slave error code

## Operation
- FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0, exactly 1 cycle.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY=1.
- Arbitration:
  - Round-robin pointer `rr_ptr`. The winner is the first requester with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Arbitration is evaluated in IDLE and in the ACCESS completion cycle.
  - req_ready[winner]=1 in that same cycle. Command fields are captured into PADDR/PWDATA/PWRITE registers at the clock edge.
  - rr_ptr ← winner+1 (wrapping) on every grant.
- Transitions:
  - IDLE → SETUP on grant.
  - SETUP → ACCESS unconditionally.
  - ACCESS with PREADY=1 → SETUP if a new grant exists (back-to-back transfer), else → IDLE.
- PREADY is sampled only in ACCESS. PREADY seen in IDLE or SETUP is ignored, because the slave keeps PREADY high one cycle after completion.
- Response capture:
  - On the ACCESS completion edge, register rsp_valid[granted]=1, rsp_rdata=PRDATA, rsp_err=PSLVERR.
  - For writes, rsp_rdata holds its previous value.
- Outputs:
  - PADDR/PWDATA/PWRITE hold stable from SETUP through the end of ACCESS.
  - Between transfers they hold their last value.
- A requester must hold req_valid and its fields stable until req_ready. The block never drops an accepted command.

## Timing
- Reset values:
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - req_ready=0 (FSM in IDLE, pointer 0).
  - rsp_valid=0, rsp_rdata=0, rsp_err=00, rr_ptr=0.
- PRESETn asserted mid-transfer forces all of the above immediately (asynchronous). The in-flight command is lost with no response.
- With the registered-PREADY slave: accept in cycle 0, SETUP in cycle 1, ACCESS in cycles 2–3 (PREADY seen in cycle 3), rsp_valid in cycle 4.
- Back-to-back: the next SETUP follows the completion cycle directly, giving a throughput of one transfer per 3 cycles.
- Simultaneous requests: exactly one winner per grant, and every continuously-valid requester is served within NUM_REQ grants.
- A response pulse and a new grant may occur in the same cycle, for different or the same requester.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - An ACCESS-cycle counter runs, cleared on entry to ACCESS.
  - When the counter reaches TIMEOUT_CYCLES without PREADY, the block aborts: PSEL/PENABLE drop (→ IDLE), rsp_valid pulses with rsp_err=11 and rsp_rdata unchanged.
  - No new grant is made in the abort cycle.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err=11 is never produced.

## Structure
- Shared package `apb_pkg` holds:
  - FSM state enum: IDLE, SETUP, ACCESS.
  - Error code constants: APB_OK=00, APB_WERR=01, APB_RERR=10, APB_TMO=11.
- Sub-module `rr_arbiter`:
  - Parameterised by NUM_REQ.
  - Inputs: request vector, pointer. Output: one-hot grant plus grant index.
  - Combinational. The caller owns the pointer register.

## Test plan
- Single write: r0 writes 0x4000_0010 with 0xDEAD_BEEF → req_ready[0] in cycle 0, PSEL in cycles 1–3, PENABLE in cycles 2–3, rsp_valid[0] in cycle 4 with rsp_err=00. A subsequent read of the same address returns 0xDEAD_BEEF.
- Error passthrough: r1 reads 0x5000_0000 → rsp_valid[1] with rsp_err=10. r1 writes 0x5000_0000 → rsp_err=01. Memory is unchanged.
- Fairness: r0 and r1 are held valid continuously from reset → grants alternate 0,1,0,1; SETUP immediately follows each completion; one rsp_valid every 3 cycles.
- Stale PREADY: back-to-back transfers → no SETUP-phase PREADY causes early completion; each ACCESS lasts 2 cycles.
- Reset mid-ACCESS: PRESETn pulsed low during cycle 2 → PSEL=PENABLE=0 asynchronously, no rsp_valid, rr_ptr=0 afterwards.
- Timeout (macro on, TIMEOUT_CYCLES=4): PREADY held 0 → PSEL drops after 4 ACCESS cycles, rsp_err=11, and the next pending request is granted from IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM state and APB error code definitions for apb_arbiter_master
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [1:0] APB_OK   = 2'b00;
    localparam logic [1:0] APB_WERR = 2'b01;
    localparam logic [1:0] APB_RERR = 2'b10;
    localparam logic [1:0] APB_TMO  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or above ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);

    int   slot;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[slot]) begin
                found         = 1'b1;
                gnt[slot]     = 1'b1;
                gnt_idx       = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/apb_arbiter_master.sv
// rtl/apb_arbiter_master.sv - round-robin APB master sharing one slave among NUM_REQ requesters
// Optional ACCESS-phase abort enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic [1:0]                PSLVERR
);

    localparam int IW = $clog2(NUM_REQ);

    apb_state_e         state, state_nxt;
    logic [IW-1:0]      rr_ptr, cur_idx, win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               done, arb_en, grant, tmo_abort;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (win_oh),
        .gnt_idx (win_idx)
    );

    // PREADY only counts in ACCESS; the slave's trailing PREADY in SETUP/IDLE is ignored.
    assign done      = (state == ACCESS) && PREADY;
    assign arb_en    = (state == IDLE) || done;
    assign grant     = arb_en && (|req_valid);
    assign req_ready = grant ? win_oh : '0;

    assign PSEL    = (state != IDLE);
    assign PENABLE = (state == ACCESS);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            tmo_cnt <= '0;
        else if (state != ACCESS)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_abort = (state == ACCESS) && !PREADY && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    // Counterless build: abort never fires; the term keeps the parameter referenced.
    assign tmo_abort = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (done)
                    state_nxt = grant ? SETUP : IDLE;
                else if (tmo_abort)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rr_ptr    <= '0;
            cur_idx   <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= APB_OK;
        end else begin
            rsp_valid <= '0;
            if (done || tmo_abort) begin
                rsp_valid <= NUM_REQ'(1) << cur_idx;
                rsp_err   <= done ? PSLVERR : APB_TMO;
                if (done && !PWRITE)
                    rsp_rdata <= PRDATA;
            end
            if (grant) begin
                PADDR   <= req_addr[win_idx*ADDR_W +: ADDR_W];
                PWDATA  <= req_wdata[win_idx*DATA_W +: DATA_W];
                PWRITE  <= req_write[win_idx];
                cur_idx <= win_idx;
                rr_ptr  <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_arbiter_master.sv
// tb/tb_apb_arbiter_master.sv - self-checking bench: transaction-level model of arbitration, bus phases and responses
module tb_apb_arbiter_master;
    import apb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, PRDATA, PWDATA;
    logic [1:0]    rsp_err, PSLVERR;
    logic          PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;

    int errors = 0;
    int checks = 0;

    logic [N-1:0]  pend = '0;
    logic [N-1:0]  pw = '0;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic          stall = 1'b0;

    apb_arbiter_master #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign req_valid = pend;
    assign req_write = pw;
    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = pa[i];
            req_wdata[i*DW +: DW] = pd[i];
        end
    end

    function automatic bit in_rng(logic [31:0] a);
        return a[31:10] == 22'h100000;
    endfunction

    // Registered-PREADY slave: ready after one ACCESS cycle, stays high one cycle past completion.
    logic [31:0] smem [256] = '{default: 32'h0};
    assign PRDATA  = in_rng(PADDR) ? smem[PADDR[9:2]] : 32'h0;
    assign PSLVERR = in_rng(PADDR) ? APB_OK : (PWRITE ? APB_WERR : APB_RERR);
    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PREADY <= 1'b0;
        end else begin
            PREADY <= PSEL && PENABLE && !stall;
            if (PSEL && PENABLE && PREADY && PWRITE && in_rng(PADDR))
                smem[PADDR[9:2]] <= PWDATA;
        end
    end

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        bit          tmo;
    } cmd_t;

    cmd_t        q[$];
    logic [31:0] mem_m [256] = '{default: 32'h0};
    logic [31:0] last_rd = 32'h0;
    int          rr_m = 0;
    int          busy_until = 0;
    int          cyc = 0;
    int          rate = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_cmd(int i, bit wr, logic [31:0] a, logic [31:0] d);
        pend[i] = 1'b1;
        pw[i]   = wr;
        pa[i]   = a;
        pd[i]   = d;
    endtask

    task automatic tick();
        logic [N-1:0] er, ev, rdy;
        logic [1:0]   xerr;
        bit           ep, ee;
        int           w, d, last;
        cmd_t         h, c;
        #1;
        ev   = '0;
        xerr = APB_OK;
        if (q.size() > 0 && q[0].cyc + (q[0].tmo ? 6 : 4) == cyc) begin
            h = q.pop_front();
            ev[h.idx] = 1'b1;
            if (h.tmo) begin
                xerr = APB_TMO;
            end else if (!in_rng(h.addr)) begin
                xerr = h.wr ? APB_WERR : APB_RERR;
                if (!h.wr) last_rd = 32'h0;
            end else if (h.wr) begin
                mem_m[h.addr[9:2]] = h.data;
            end else begin
                last_rd = mem_m[h.addr[9:2]];
            end
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev != '0) begin
            chk("rsp_err", 64'(rsp_err), 64'(xerr));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(last_rd));
        end
        ep = 1'b0;
        ee = 1'b0;
        if (q.size() > 0) begin
            d    = cyc - q[0].cyc;
            last = q[0].tmo ? 5 : 3;
            ep   = (d >= 1) && (d <= last);
            ee   = (d >= 2) && (d <= last);
            if (ep) begin
                chk("PADDR", 64'(PADDR), 64'(q[0].addr));
                chk("PWRITE", 64'(PWRITE), 64'(q[0].wr));
                if (q[0].wr) chk("PWDATA", 64'(PWDATA), 64'(q[0].data));
            end
        end
        chk("PSEL", 64'(PSEL), 64'(ep));
        chk("PENABLE", 64'(PENABLE), 64'(ee));
        er = '0;
        if (cyc >= busy_until && pend != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && pend[(rr_m + k) % N]) w = (rr_m + k) % N;
            er[w]  = 1'b1;
            c.idx  = w;
            c.wr   = pw[w];
            c.addr = pa[w];
            c.data = pd[w];
            c.cyc  = cyc;
            c.tmo  = stall;
            q.push_back(c);
            rr_m       = (w + 1) % N;
            busy_until = cyc + (stall ? 6 : 3);
        end
        chk("req_ready", 64'(req_ready), 64'(er));
        rdy = req_ready;
        @(posedge PCLK);
        #1;
        cyc++;
        pend = pend & ~rdy;
        for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(99) < rate)
                set_cmd(i, 1'($urandom_range(1)),
                        ($urandom_range(4) == 0) ? 32'h5000_0000
                                                 : (32'h4000_0000 | (32'($urandom_range(7)) << 2)),
                        $urandom);
        @(negedge PCLK);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pd[i] = '0;
        end
        #1;
        chk("rst PSEL", 64'(PSEL), 64'(0));
        chk("rst PENABLE", 64'(PENABLE), 64'(0));
        chk("rst PWRITE", 64'(PWRITE), 64'(0));
        chk("rst PADDR", 64'(PADDR), 64'(0));
        chk("rst PWDATA", 64'(PWDATA), 64'(0));
        chk("rst req_ready", 64'(req_ready), 64'(0));
        chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst rsp_err", 64'(rsp_err), 64'(0));
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);

        // single write then readback
        set_cmd(0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        run(6);
        set_cmd(0, 1'b0, 32'h4000_0010, 32'h0);
        run(6);
        chk("readback", 64'(rsp_rdata), 64'h0000_0000_DEAD_BEEF);

        // error passthrough
        set_cmd(1, 1'b0, 32'h5000_0000, 32'h0);
        run(6);
        set_cmd(1, 1'b1, 32'h5000_0000, 32'h1234_5678);
        run(6);

        // continuous requests from both, then random traffic
        rate = 100;
        set_cmd(0, 1'b1, 32'h4000_0004, $urandom);
        set_cmd(1, 1'b1, 32'h4000_0008, $urandom);
        run(40);
        rate = 30;
        run(300);
        rate = 0;
        run(10);

        // reset during ACCESS
        set_cmd(0, 1'b1, 32'h4000_0020, 32'hCAFE_F00D);
        run(2);
        #1 PRESETn = 1'b0;
        #1;
        chk("midrst PSEL", 64'(PSEL), 64'(0));
        chk("midrst PENABLE", 64'(PENABLE), 64'(0));
        chk("midrst rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst PADDR", 64'(PADDR), 64'(0));
        q.delete();
        rr_m       = 0;
        busy_until = 0;
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        cyc++;
        @(negedge PCLK);
        set_cmd(0, 1'b0, 32'h4000_0020, 32'h0);
        set_cmd(1, 1'b0, 32'h4000_0004, 32'h0);
        run(12);

`ifdef APB_ARB_TIMEOUT_EN
        stall = 1'b1;
        run(2);
        set_cmd(0, 1'b0, 32'h4000_0010, 32'h0);
        set_cmd(1, 1'b1, 32'h4000_0014, 32'h5555_AAAA);
        run(16);
        stall = 1'b0;
        run(4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
